// File: rtl/dense_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dense_fetch_pkg
// Brief    : Shared types and constants for the dense-layer weight fetcher.
// Revision : 1.0 - initial release
// ============================================================================
package dense_fetch_pkg;

    // Number of int8 weights packed into one ROM word.
    localparam int WORDS_PER_INT8 = 4;
    // Data width carried through the output buffer; matches the ROM word.
    localparam int FETCH_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] data;
        logic                   row_last;
        logic                   layer_last;
    } fetch_word_t;

endpackage
`default_nettype wire

// File: rtl/dense_weight_fetcher_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous first-word-fall-through FIFO of fetch_word_t entries.
//            Push and pop in the same cycle are allowed, including when full.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import dense_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  fetch_word_t                  i_data,
    input  logic                         i_pop,
    output fetch_word_t                  o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    fetch_word_t       r_mem [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    // Pointer and occupancy bookkeeping; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because the head is qualified by count.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dense_weight_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : dense_weight_fetcher
// Brief    : Walks one dense layer's weights row-major out of the weight ROM
//            (1-cycle read latency), buffers them in a small FIFO and presents
//            them as a valid/ready stream tagged with row_last / layer_last.
//            Optional macro DENSE_FETCH_BOUNDS_CHECK_EN adds a bounds_err port
//            and refuses layers that would run past the end of the ROM.
// Revision : 1.0 - initial release
// ============================================================================
module dense_weight_fetcher
    import dense_fetch_pkg::*;
#(
    parameter int DEPTH        = 16384,
    parameter int WIDTH        = 32,
    parameter int MAX_FEATURES = 1024,
    parameter int FIFO_DEPTH   = 4,
    localparam int c_AW        = $clog2(DEPTH),
    localparam int c_FW        = $clog2(MAX_FEATURES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [c_AW-1:0]  base_addr,
    input  logic [c_FW-1:0]  in_features,
    input  logic [c_FW-1:0]  out_features,
    output logic [c_AW-1:0]  rom_addr,
    output logic             rom_read_enable,
    input  logic [WIDTH-1:0] rom_weight,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [WIDTH-1:0] w_data,
    output logic             w_row_last,
    output logic             w_layer_last,
    output logic             busy,
    output logic             done
`ifdef DENSE_FETCH_BOUNDS_CHECK_EN
    ,
    output logic             bounds_err
`endif
);

    localparam int c_CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     r_state;
    logic [c_AW-1:0]  r_addr;
    logic [c_FW-1:0]  r_wpr;
    logic [c_FW-1:0]  r_out;
    logic [c_FW-1:0]  r_col;
    logic [c_FW-1:0]  r_row;
    logic             r_inflight;
    logic             r_tag_row_last;
    logic             r_tag_layer_last;

    logic [c_FW+1:0]  w_wpr_sum;
    logic [c_FW-1:0]  w_wpr;
    logic             w_zero;
    logic             w_oob;
    logic             w_col_last;
    logic             w_row_is_last;
    logic [c_CW-1:0]  w_count;
    logic [c_CW:0]    w_credit;
    logic             w_issue;
    logic             w_pop;
    logic             w_drained;
    fetch_word_t      w_push_word;
    fetch_word_t      w_head;

    // Words per row = ceil(in_features / 4), computed from the live ports at start.
    assign w_wpr_sum = {2'b00, in_features} + (c_FW+2)'(WORDS_PER_INT8 - 1);
    assign w_wpr     = c_FW'(w_wpr_sum / (c_FW+2)'(WORDS_PER_INT8));
    assign w_zero    = (in_features == '0) || (out_features == '0);

`ifdef DENSE_FETCH_BOUNDS_CHECK_EN
    localparam int c_BW = c_AW + 2 * c_FW + 1;
    logic [c_BW-1:0] w_span_end;
    logic            r_bounds_err;

    assign w_span_end = c_BW'(base_addr) + c_BW'(w_wpr) * c_BW'(out_features);
    assign w_oob      = w_span_end > c_BW'(DEPTH);

    // Error flag is re-evaluated on every accepted start and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bounds_err <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_bounds_err <= w_oob;
        end
    end

    assign bounds_err = r_bounds_err;
`else
    assign w_oob = 1'b0;
`endif

    assign w_col_last    = (r_col == r_wpr - c_FW'(1));
    assign w_row_is_last = (r_row == r_out - c_FW'(1));

    // Credit counts buffered plus in-flight words, crediting back a same-cycle pop
    // so a consumer that is always ready sees one word per clock.
    assign w_pop    = w_valid && w_ready;
    assign w_credit = (c_CW+1)'(w_count) + (c_CW+1)'(r_inflight) - (c_CW+1)'(w_pop);
    assign w_issue  = (r_state == ISSUE) && (w_credit < (c_CW+1)'(FIFO_DEPTH));

    // Drain completes when the FIFO empties this cycle and nothing is still returning.
    assign w_drained = !r_inflight && (w_count == c_CW'(w_pop));

    // Sequencer: operand latch, row/column walk with a running address, and tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_addr           <= '0;
            r_wpr            <= '0;
            r_out            <= '0;
            r_col            <= '0;
            r_row            <= '0;
            r_inflight       <= 1'b0;
            r_tag_row_last   <= 1'b0;
            r_tag_layer_last <= 1'b0;
        end else begin
            r_inflight <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_wpr  <= w_wpr;
                        r_out  <= out_features;
                        r_addr <= base_addr;
                        r_col  <= '0;
                        r_row  <= '0;
                        r_state <= (w_zero || w_oob) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_inflight       <= 1'b1;
                        r_tag_row_last   <= w_col_last;
                        r_tag_layer_last <= w_col_last && w_row_is_last;
                        // Row-major layout makes base + row*wpr + col a simple increment.
                        r_addr           <= r_addr + c_AW'(1);
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + c_FW'(1);
                            if (w_row_is_last) r_state <= DRAIN;
                        end else begin
                            r_col <= r_col + c_FW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_drained) r_state <= FINISH;
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_push_word = '{data: rom_weight, row_last: r_tag_row_last, layer_last: r_tag_layer_last};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_inflight),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign rom_addr        = r_addr;
    assign rom_read_enable = w_issue;
    assign w_valid         = (w_count != '0);
    assign w_data          = w_valid ? w_head.data : '0;
    assign w_row_last      = w_valid && w_head.row_last;
    assign w_layer_last    = w_valid && w_head.layer_last;
    assign busy            = (r_state != IDLE);
    assign done            = (r_state == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_dense_weight_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_weight_fetcher
// Brief    : Self-checking bench for dense_weight_fetcher. A behavioural ROM
//            and a list-based model of the expected weight stream are compared
//            with what the DUT issues and delivers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_weight_fetcher;

    localparam int DEPTH = 16384;
    localparam int WIDTH = 32;
    localparam int FD    = 4;
    localparam int AW    = 14;
    localparam int FW    = 11;

    logic             clk = 1'b0;
    logic             reset, start, w_ready;
    logic [AW-1:0]    base_addr, rom_addr;
    logic [FW-1:0]    in_features, out_features;
    logic             rom_read_enable, w_valid, w_row_last, w_layer_last, busy, done;
    logic [WIDTH-1:0] rom_weight, w_data;
    logic             berr;
`ifdef DENSE_FETCH_BOUNDS_CHECK_EN
    logic             bounds_err;
    assign berr = bounds_err;
`else
    assign berr = 1'b0;
`endif

    dense_weight_fetcher dut (
        .clk (clk), .reset (reset), .start (start), .base_addr (base_addr),
        .in_features (in_features), .out_features (out_features),
        .rom_addr (rom_addr), .rom_read_enable (rom_read_enable), .rom_weight (rom_weight),
        .w_valid (w_valid), .w_ready (w_ready), .w_data (w_data),
        .w_row_last (w_row_last), .w_layer_last (w_layer_last),
        .busy (busy), .done (done)
`ifdef DENSE_FETCH_BOUNDS_CHECK_EN
        , .bounds_err (bounds_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] rom_fn(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h0F1E2D3C;
    endfunction

    // Behavioural ROM: one-cycle latency, garbage when not read.
    always @(posedge clk) rom_weight <= rom_read_enable ? rom_fn(int'(rom_addr)) : $urandom;

    // Monitor, sampled mid-cycle.
    logic [AW-1:0] q_addr[$];
    logic [33:0]   q_got[$];
    int cyc = 0, n_iss, n_acc, max_out, n_done, done_cyc, first_acc, last_acc, busy_cyc, n_unstable;
    logic done_err, prev_stall;
    logic [33:0] prev_word;

    always @(negedge clk) begin
        cyc++;
        if (prev_stall && (!w_valid || {w_data, w_row_last, w_layer_last} != prev_word)) n_unstable++;
        prev_stall = w_valid && !w_ready;
        prev_word  = {w_data, w_row_last, w_layer_last};
        if (rom_read_enable) begin q_addr.push_back(rom_addr); n_iss++; end
        if (w_valid && w_ready) begin
            q_got.push_back({w_data, w_row_last, w_layer_last});
            if (n_acc == 0) first_acc = cyc;
            n_acc++;
            last_acc = cyc;
        end
        if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
        if (busy) busy_cyc++;
        if (done) begin n_done++; done_cyc = cyc; done_err = berr; end
    end

    // Reference expectations.
    logic [AW-1:0] exp_addr[$];
    logic [33:0]   exp_word[$];
    logic          exp_err;
    logic          timed_out;

    task automatic clear_mon();
        q_addr.delete(); q_got.delete();
        n_iss = 0; n_acc = 0; max_out = 0; n_done = 0; done_cyc = -1;
        first_acc = -1; last_acc = -1; busy_cyc = 0; n_unstable = 0; prev_stall = 1'b0;
    endtask

    task automatic set_ready(input int mode, input int k);
        case (mode)
            0:       w_ready = 1'b1;
            1:       w_ready = 1'($urandom_range(0, 1));
            default: w_ready = !(k >= 6 && k < 16);
        endcase
    endtask

    // Launch one layer, build its expected stream, and run until done (bounded).
    task automatic drive_layer(input int base, input int nin, input int nout, input int mode);
        int wpr = (nin + 3) / 4;
        exp_addr.delete(); exp_word.delete(); exp_err = 1'b0;
`ifdef DENSE_FETCH_BOUNDS_CHECK_EN
        if (nin != 0 && nout != 0 && base + wpr * nout > DEPTH) exp_err = 1'b1;
`endif
        if (!exp_err)
            for (int r = 0; r < nout; r++)
                for (int c = 0; c < wpr; c++) begin
                    int a = (base + r * wpr + c) % DEPTH;
                    exp_addr.push_back(AW'(a));
                    exp_word.push_back({rom_fn(a), c == wpr - 1, (c == wpr - 1) && (r == nout - 1)});
                end
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1; base_addr = AW'(base); in_features = FW'(nin); out_features = FW'(nout);
        set_ready(mode, 0);
        @(posedge clk); #1;
        start = $urandom_range(0, 1); base_addr = AW'($urandom);
        in_features = FW'($urandom); out_features = FW'($urandom);
        timed_out = 1'b1;
        for (int k = 1; k < 3000; k++) begin
            set_ready(mode, k);
            @(posedge clk); #1;
            if (n_done > 0) begin timed_out = 1'b0; break; end
        end
        start = 1'b0; w_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; w_ready = 1'b1;
        base_addr = AW'($urandom); in_features = FW'($urandom); out_features = FW'($urandom);
        repeat (3) @(negedge clk);
        total++;
        if ({rom_addr, rom_read_enable, w_valid, w_data, w_row_last, w_layer_last, busy, done, berr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got addr=%h re=%b v=%b data=%h rl=%b ll=%b busy=%b done=%b err=%b, want all zero",
                     rom_addr, rom_read_enable, w_valid, w_data, w_row_last, w_layer_last, busy, done, berr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Fixed shapes: 8x2, 5x3 (partial last word), and a layer near the ROM end.
    task automatic test_shapes();
        int tb_base[3] = '{32'h100, 32'h2A0, 16380};
        int tb_in[3]   = '{8, 5, 16};
        int tb_out[3]  = '{2, 3, 2};
        for (int t = 0; t < 3; t++) begin
            drive_layer(tb_base[t], tb_in[t], tb_out[t], 0);
            total++;
            if (timed_out || n_done != 1) begin bad++; $display("FAIL shape%0d_done: got %0d pulses (timeout=%b), want 1", t, n_done, timed_out); end
            total++;
            if (done_err !== exp_err) begin bad++; $display("FAIL shape%0d_err: got %b, want %b", t, done_err, exp_err); end
            total++;
            if (q_addr.size() != exp_addr.size() || q_got.size() != exp_word.size()) begin
                bad++; $display("FAIL shape%0d_count: got reads=%0d words=%0d, want %0d", t, q_addr.size(), q_got.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    total++;
                    if (q_addr[i] !== exp_addr[i] || q_got[i] !== exp_word[i]) begin
                        bad++; $display("FAIL shape%0d_word%0d: got addr=%h word=%h, want addr=%h word=%h", t, i, q_addr[i], q_got[i], exp_addr[i], exp_word[i]);
                    end
                end
                if (exp_word.size() > 0) begin
                    total++;
                    if (done_cyc != last_acc + 1 || last_acc - first_acc != exp_word.size() - 1) begin
                        bad++; $display("FAIL shape%0d_timing: got first=%0d last=%0d done=%0d, want back-to-back and done=last+1", t, first_acc, last_acc, done_cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_zero();
        for (int t = 0; t < 2; t++) begin
            drive_layer(32'h40, t == 0 ? 0 : 12, t == 0 ? 3 : 0, 0);
            total++;
            if (n_iss != 0 || n_done != 1 || busy_cyc != 1) begin
                bad++; $display("FAIL zero%0d: got reads=%0d done=%0d busy_cycles=%0d, want 0/1/1", t, n_iss, n_done, busy_cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        drive_layer($urandom_range(0, 4000), 256, 1, 2);
        total++;
        if (max_out != FD) begin bad++; $display("FAIL bp_outstanding: got max=%0d, want %0d", max_out, FD); end
        total++;
        if (n_unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d changes under stall, want 0", n_unstable); end
        total++;
        if (q_got.size() != exp_word.size() || q_addr.size() != exp_addr.size() || n_done != 1) begin
            bad++; $display("FAIL bp_count: got words=%0d reads=%0d done=%0d, want %0d/%0d/1", q_got.size(), q_addr.size(), n_done, exp_word.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_word.size(); i++) begin
                total++;
                if (q_got[i] !== exp_word[i]) begin bad++; $display("FAIL bp_word%0d: got %h, want %h", i, q_got[i], exp_word[i]); end
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            drive_layer($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), $urandom_range(1, 6), 1);
            total++;
            if (n_done != 1 || done_err !== exp_err || max_out > FD || q_got.size() != exp_word.size() || q_addr.size() != exp_addr.size()) begin
                bad++; $display("FAIL rand%0d_summary: got done=%0d err=%b max=%0d words=%0d reads=%0d, want 1/%b/<=%0d/%0d/%0d",
                                t, n_done, done_err, max_out, q_got.size(), q_addr.size(), exp_err, FD, exp_word.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_word.size(); i++) begin
                    total++;
                    if (q_got[i] !== exp_word[i] || q_addr[i] !== exp_addr[i]) begin
                        bad++; $display("FAIL rand%0d_word%0d: got %h@%h, want %h@%h", t, i, q_got[i], q_addr[i], exp_word[i], exp_addr[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        @(posedge clk); #1;
        clear_mon();
        w_ready = 1'b0; start = 1'b1; base_addr = AW'(32'h300); in_features = FW'(64); out_features = FW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 0; k < 50 && n_iss < 4; k++) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (w_valid !== 1'b1) begin bad++; $display("FAIL midreset_buffered: got w_valid=%b before reset, want 1", w_valid); end
        @(negedge clk);
        total++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midreset_abort: got v=%b busy=%b done=%b, want 0/0/0", w_valid, busy, done);
        end
        @(posedge clk); #1;
        reset = 1'b0; w_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (n_done != 0) begin bad++; $display("FAIL midreset_nodone: got %0d done pulses, want 0", n_done); end
        drive_layer(32'h300, 12, 2, 0);
        total++;
        if (n_done != 1 || q_got.size() != exp_word.size() || q_got.size() == 0 || q_got[0] !== exp_word[0] || q_got[q_got.size()-1] !== exp_word[exp_word.size()-1]) begin
            bad++; $display("FAIL midreset_restart: got done=%0d words=%0d, want 1/%0d with matching ends", n_done, q_got.size(), exp_word.size());
        end
    endtask

    initial begin
        test_reset();
        test_shapes();
        test_zero();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
